// File: rtl/env_pdm_out_if.sv
// env_pdm_out_if: bundles the control inputs and audio outputs of the
// envelope / sigma-delta output stage.
//   master modport : drives the sample, gate, rate and sustain controls;
//                    observes the envelope state, envelope, amplitude and PDM bit
//   slave modport  : the output stage itself (the reverse directions)
//   wave_in        : raw oscillator sample
//   sample_en      : latch wave_in this cycle
//   gate           : note on (1) / off (0), level-sensitive
//   attack_rate    : attack step period select
//   release_rate   : decay and release step period select
//   sustain_level  : sustain target
//   env_state      : current envelope FSM state
//   env            : current envelope value
//   amp_out        : sample scaled by the envelope
//   pdm_out        : sigma-delta bitstream
interface env_pdm_out_if #(
   parameter int WAVE_BITS = 8,
   parameter int ENV_BITS  = 8,
   parameter int RATE_BITS = 4
);
   logic [WAVE_BITS-1:0] wave_in;
   logic                 sample_en;
   logic                 gate;
   logic [RATE_BITS-1:0] attack_rate;
   logic [RATE_BITS-1:0] release_rate;
   logic [ENV_BITS-1:0]  sustain_level;
   logic [2:0]           env_state;
   logic [ENV_BITS-1:0]  env;
   logic [WAVE_BITS-1:0] amp_out;
   logic                 pdm_out;

   modport master (
      output wave_in, sample_en, gate, attack_rate, release_rate, sustain_level,
      input  env_state, env, amp_out, pdm_out
   );

   modport slave (
      input  wave_in, sample_en, gate, attack_rate, release_rate, sustain_level,
      output env_state, env, amp_out, pdm_out
   );
endinterface

// File: rtl/env_pdm_out.sv
// env_pdm_out: output stage behind the oscillator. Latches the raw wave
// sample, scales it by an ADSR envelope and turns the scaled amplitude into a
// 1-bit pulse-density stream with a first-order sigma-delta modulator; an
// external RC low-pass filter recovers the audio.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   ena   : design enable; when low every register holds
//   bus   : env_pdm_out_if slave modport (sample, gate, rates, sustain in;
//           env_state, env, amp_out, pdm_out out)
module env_pdm_out #(
   parameter int WAVE_BITS = 8,
   parameter int ENV_BITS  = 8,
   parameter int RATE_BITS = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           ena,
   env_pdm_out_if.slave   bus
);

   localparam int PS_BITS   = (2 ** RATE_BITS) - 1;
   localparam int PROD_BITS = WAVE_BITS + ENV_BITS;
   localparam logic [ENV_BITS-1:0] ENV_MAX = '1;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ATTACK  = 3'd1,
      S_DECAY   = 3'd2,
      S_SUSTAIN = 3'd3,
      S_RELEASE = 3'd4
   } state_t;

   state_t               state;
   state_t               state_next;
   logic [ENV_BITS-1:0]  env;
   logic [ENV_BITS-1:0]  env_next;
   logic [WAVE_BITS-1:0] wave_reg;
   logic [PS_BITS-1:0]   prescaler;
   logic [WAVE_BITS-1:0] amp;
   logic [WAVE_BITS-1:0] acc;
   logic                 pdm;
   logic                 tick_attack;
   logic                 tick_release;
   logic [PROD_BITS-1:0] product;
   logic [WAVE_BITS:0]   sd_sum;

   // A rate r ticks whenever the low r prescaler bits are all ones,
   // i.e. once every 2^r cycles.
   function automatic logic rate_tick(input logic [RATE_BITS-1:0] r,
                                      input logic [PS_BITS-1:0]   ps);
      logic [PS_BITS-1:0] mask;
      mask = ~({PS_BITS{1'b1}} << r);
      return (ps & mask) == mask;
   endfunction

   assign tick_attack  = rate_tick(bus.attack_rate, prescaler);
   assign tick_release = rate_tick(bus.release_rate, prescaler);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         env   <= '0;
      end else if (ena) begin
         state <= state_next;
         env   <= env_next;
      end
   end

   // Gate changes win over a rate tick in the same cycle: the transition
   // happens and the envelope step is skipped.
   always_comb begin
      state_next = state;
      env_next   = env;
      case (state)
         S_IDLE: begin
            env_next = '0;
            if (bus.gate) state_next = S_ATTACK;
         end
         S_ATTACK: begin
            if (!bus.gate)               state_next = S_RELEASE;
            else if (env == ENV_MAX)     state_next = S_DECAY;
            else if (tick_attack)        env_next   = env + ENV_BITS'(1);
         end
         S_DECAY: begin
            if (!bus.gate) begin
               state_next = S_RELEASE;
            end else if (tick_release) begin
               if (env > bus.sustain_level) env_next   = env - ENV_BITS'(1);
               else                         state_next = S_SUSTAIN;
            end
         end
         S_SUSTAIN: begin
            if (!bus.gate) state_next = S_RELEASE;
         end
         S_RELEASE: begin
            if (bus.gate) begin
               state_next = S_ATTACK;
            end else if (tick_release) begin
               if (env == '0) state_next = S_IDLE;
               else           env_next   = env - ENV_BITS'(1);
            end
         end
         default: begin
            state_next = S_IDLE;
            env_next   = '0;
         end
      endcase
   end

   assign product = PROD_BITS'(wave_reg) * PROD_BITS'(env);
   assign sd_sum  = {1'b0, acc} + {1'b0, amp};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wave_reg  <= '0;
         prescaler <= '0;
         amp       <= '0;
         acc       <= '0;
         pdm       <= 1'b0;
      end else if (ena) begin
         if (bus.sample_en) wave_reg <= bus.wave_in;
         prescaler <= prescaler + PS_BITS'(1);
         amp       <= product[PROD_BITS-1:ENV_BITS];
         // Carry out of the accumulator is the pulse; its density is amp/2^WAVE_BITS.
         acc       <= sd_sum[WAVE_BITS-1:0];
         pdm       <= sd_sum[WAVE_BITS];
      end
   end

   assign bus.env_state = state;
   assign bus.env       = env;
   assign bus.amp_out   = amp;
   assign bus.pdm_out   = pdm;

endmodule
